parity_ecc_scrubber: RTL and testbench



---
 rtl/parity_ecc_scrubber.sv | 158 +++++++++++++++
 tb/tb_parity_ecc_scrubber.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_ecc_scrubber.sv
// parity_ecc_scrubber: background parity scrubber for {data, parity} memories.
// Walks cfg_num_words addresses from cfg_base_addr, one outstanding read at a
// time. It checks even parity on each response and reports the error count,
// the first failing address, a done pulse and a sticky irq.
// Optional macro SCRUB_THROTTLE_EN adds cfg_gap and a GAP state. GAP inserts
// idle cycles between a non-final response and the next request.
module parity_ecc_scrubber #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [ADDR_WIDTH:0]   cfg_num_words,
`ifdef SCRUB_THROTTLE_EN
   input  logic [7:0]            cfg_gap,
`endif
   input  logic                  err_clr,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH:0]   mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic                  first_err_valid,
   output logic                  irq
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DONE
`ifdef SCRUB_THROTTLE_EN
      , S_GAP
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  abort;
   logic                  rsp, par_err;
`ifdef SCRUB_THROTTLE_EN
   logic [7:0]            gap_cfg, gap_cnt;
`endif

   // A response only counts while a read is outstanding.
   assign rsp     = (state == S_WAIT) && mem_rvalid;
   assign par_err = rsp && (mem_rdata[0] != ^mem_rdata[DATA_WIDTH:1]);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a grant in the same cycle as stop wins over the stop
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = (cfg_num_words == '0) ? S_DONE : S_REQ;
         S_REQ: begin
            if (mem_gnt)   state_nxt = S_WAIT;
            else if (stop) state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (abort || stop)       state_nxt = S_IDLE;
               else if (remaining == 1) state_nxt = S_DONE;
`ifdef SCRUB_THROTTLE_EN
               else                     state_nxt = (gap_cfg == '0) ? S_REQ : S_GAP;
`else
               else                     state_nxt = S_REQ;
`endif
            end
         end
         S_DONE: state_nxt = S_IDLE;
`ifdef SCRUB_THROTTLE_EN
         S_GAP: begin
            if (stop)               state_nxt = S_IDLE;
            else if (gap_cnt <= 1)  state_nxt = S_REQ;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      mem_req  = (state == S_REQ);
      mem_addr = cur_addr;
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
   end

   // Pass bookkeeping: address walk, words left, abort request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         remaining <= '0;
         abort     <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            cur_addr  <= cfg_base_addr;
            remaining <= cfg_num_words;
            abort     <= 1'b0;
         end
         // Stop after the grant must still drain the outstanding read.
         if ((state == S_REQ && mem_gnt && stop) || (state == S_WAIT && stop))
            abort <= 1'b1;
         if (rsp) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

`ifdef SCRUB_THROTTLE_EN
   // Gap length is frozen at start; the counter reloads on each response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cfg <= '0;
         gap_cnt <= '0;
      end else begin
         if (state == S_IDLE && start) gap_cfg <= cfg_gap;
         if (rsp)                      gap_cnt <= gap_cfg;
         else if (state == S_GAP)      gap_cnt <= gap_cnt - 1'b1;
      end
   end
`endif

   // Error status; a clear in the same cycle drops the new error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count       <= '0;
         first_err_addr  <= '0;
         first_err_valid <= 1'b0;
         irq             <= 1'b0;
      end else if (err_clr) begin
         err_count       <= '0;
         first_err_addr  <= '0;
         first_err_valid <= 1'b0;
         irq             <= 1'b0;
      end else if (par_err) begin
         if (!(&err_count)) err_count <= err_count + 1'b1;
         irq <= 1'b1;
         if (!first_err_valid) begin
            first_err_addr  <= cur_addr;
            first_err_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parity_ecc_scrubber.sv
// Directed bench for parity_ecc_scrubber. A table of scrub passes is checked
// against hand-computed status. Short sequences then cover grant stalls, stop
// in REQ and WAIT, counter saturation and err_clr.
module tb_parity_ecc_scrubber;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, err_clr;
   logic [9:0]  cfg_base_addr;
   logic [10:0] cfg_num_words;
   logic [7:0]  gap;
   logic        mem_gnt, mem_rvalid;
   logic [8:0]  mem_rdata;
   logic        mem_req, busy, done, first_err_valid, irq;
   logic [9:0]  mem_addr, first_err_addr;
   logic [15:0] err_count;
   logic        s_mem_req, s_busy, s_done, s_fev, s_irq;
   logic [9:0]  s_mem_addr, s_fea;
   logic [1:0]  s_err_count;

   always #5 clk = ~clk;

   parity_ecc_scrubber #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
`ifdef SCRUB_THROTTLE_EN
      .cfg_gap(gap),
`endif
      .err_clr(err_clr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_valid(first_err_valid), .irq(irq));

   // Narrow-counter copy on the same stimulus, used for saturation checks.
   parity_ecc_scrubber #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
`ifdef SCRUB_THROTTLE_EN
      .cfg_gap(gap),
`endif
      .err_clr(err_clr), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(s_busy), .done(s_done), .err_count(s_err_count),
      .first_err_addr(s_fea), .first_err_valid(s_fev), .irq(s_irq));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model: 1-cycle read latency, grant observed at the negedge.
   logic [8:0] mem [0:1023];
   logic       auto_rsp = 1'b1;
   logic       hit = 1'b0;
   logic [9:0] haddr = '0;
   int         cyc = 0;
   int         done_cnt = 0;
   logic [9:0] req_log [$];
   int         req_cyc [$];

   initial forever begin
      @(negedge clk);
      cyc++;
      hit = mem_req && mem_gnt;
      haddr = mem_addr;
      if (hit) begin
         req_log.push_back(mem_addr);
         req_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         mem_rvalid = hit;
         mem_rdata  = hit ? mem[haddr] : 9'h000;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_errs();
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
   endtask

   task automatic do_start(input logic [9:0] base, input logic [10:0] num);
      req_log.delete(); req_cyc.delete(); done_cnt = 0;
      cfg_base_addr = base; cfg_num_words = num;
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (k == 300) chk({name, "_timeout"}, 1, 0);
      tick(1);
   endtask

   typedef struct {
      logic [9:0]  base;
      logic [10:0] num;
      logic [3:0]  bad;
      logic [15:0] exp_cnt;
      logic [9:0]  exp_fea;
      logic        exp_fev;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{10'h010, 11'd4, 4'b0000, 16'd0, 10'h000, 1'b0};
      vecs[1] = '{10'h010, 11'd4, 4'b0100, 16'd1, 10'h012, 1'b1};
      vecs[2] = '{10'h010, 11'd4, 4'b1100, 16'd2, 10'h012, 1'b1};
      vecs[3] = '{10'h3FE, 11'd4, 4'b0000, 16'd0, 10'h000, 1'b0};
      vecs[4] = '{10'h3FE, 11'd4, 4'b0100, 16'd1, 10'h000, 1'b1};
      vecs[5] = '{10'h100, 11'd0, 4'b0000, 16'd0, 10'h000, 1'b0};

      for (int i = 0; i < 1024; i++) mem[i] = 9'h1FE;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; err_clr = 1'b0;
      cfg_base_addr = '0; cfg_num_words = '0; gap = 8'd0;
      mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(3);
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_first_err", {first_err_valid, first_err_addr}, 0);
      chk("rst_irq", irq, 0);
      rst_n = 1'b1;
      tick(2);

      // Table-driven passes
      for (int v = 0; v < 6; v++) begin
         logic [9:0] a;
         for (int i = 0; i < 4; i++) begin
            a = vecs[v].base + 10'(i);
            if (vecs[v].bad[i]) mem[a] = 9'h1FF;
         end
         clear_errs();
         do_start(vecs[v].base, vecs[v].num);
         wait_idle($sformatf("v%0d", v));
         chk($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_cnt);
         chk($sformatf("v%0d_first_err_valid", v), first_err_valid, vecs[v].exp_fev);
         chk($sformatf("v%0d_first_err_addr", v), first_err_addr, vecs[v].exp_fea);
         chk($sformatf("v%0d_irq", v), irq, vecs[v].exp_fev);
         chk($sformatf("v%0d_req_count", v), req_log.size(), 32'(vecs[v].num));
         chk($sformatf("v%0d_done_count", v), done_cnt, 1);
         for (int i = 0; i < req_log.size(); i++) begin
            a = vecs[v].base + 10'(i);
            chk($sformatf("v%0d_addr%0d", v, i), req_log[i], a);
            if (i > 0) chk($sformatf("v%0d_spacing%0d", v, i), req_cyc[i] - req_cyc[i-1], 2);
         end
         for (int i = 0; i < 4; i++) begin
            a = vecs[v].base + 10'(i);
            mem[a] = 9'h1FE;
         end
      end

      // Grant withheld: request must hold steady, then stop drops it
      clear_errs();
      mem_gnt = 1'b0;
      do_start(10'h155, 11'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall_req%0d", i), mem_req, 1);
         chk($sformatf("stall_addr%0d", i), mem_addr, 10'h155);
      end
      tick(0);
      @(posedge clk); #1;
      stop = 1'b1; tick(1); stop = 1'b0;
      @(negedge clk);
      chk("stop_req_drop", mem_req, 0);
      chk("stop_req_idle", busy, 0);
      mem_gnt = 1'b1;
      tick(2);
      chk("stop_req_no_done", done_cnt, 0);
      chk("stop_req_no_grant", req_log.size(), 0);

      // Stop while a bad response is outstanding: still counted, no done
      clear_errs();
      auto_rsp = 1'b0; mem_rvalid = 1'b0;
      do_start(10'h020, 11'd3);
      tick(1);
      stop = 1'b1; tick(1); stop = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 9'h001; tick(1);
      mem_rvalid = 1'b0; mem_rdata = 9'h000;
      @(negedge clk);
      chk("stop_wait_err_count", err_count, 1);
      chk("stop_wait_first_addr", first_err_addr, 10'h020);
      chk("stop_wait_irq", irq, 1);
      chk("stop_wait_idle", busy, 0);
      tick(3);
      chk("stop_wait_no_done", done_cnt, 0);
      chk("stop_wait_one_req", req_log.size(), 1);

      // Clear coinciding with an error: the clear wins
      clear_errs();
      do_start(10'h030, 11'd1);
      tick(1);
      mem_rvalid = 1'b1; mem_rdata = 9'h001; err_clr = 1'b1; tick(1);
      mem_rvalid = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      chk("clr_wins_count", err_count, 0);
      chk("clr_wins_irq", irq, 0);
      tick(2);
      auto_rsp = 1'b1;

      // Saturation on the 2-bit counter: five bad words
      clear_errs();
      for (int i = 0; i < 5; i++) mem[10'h040 + i] = 9'h1FF;
      do_start(10'h040, 11'd5);
      wait_idle("sat");
      chk("sat_count_narrow", s_err_count, 2'd3);
      chk("sat_count_wide", err_count, 5);
      chk("sat_first_addr", s_fea, 10'h040);
      chk("sat_irq", s_irq, 1);
      clear_errs();
      @(negedge clk);
      chk("clr_count", s_err_count, 0);
      chk("clr_first", {s_fev, s_fea}, 0);
      chk("clr_irq", s_irq, 0);
      chk("clr_wide", {irq, first_err_valid, err_count}, 0);
      for (int i = 0; i < 5; i++) mem[10'h040 + i] = 9'h1FE;

`ifdef SCRUB_THROTTLE_EN
      // Throttled pass: WAIT plus 3 GAP cycles between grants
      gap = 8'd3;
      clear_errs();
      do_start(10'h050, 11'd3);
      gap = 8'd0;
      wait_idle("gap");
      chk("gap_req_count", req_log.size(), 3);
      chk("gap_done", done_cnt, 1);
      for (int i = 1; i < req_log.size(); i++)
         chk($sformatf("gap_spacing%0d", i), req_cyc[i] - req_cyc[i-1], 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
